receptor_uart: RTL and testbench
================================

# receptor_uart

Asynchronous 8N1 serial receiver for the Bluetooth module link, sitting directly downstream of the receive-side frequency divider stage. It runs on the system clock, using an internal bit-period counter whose period is the divider's half-period (5201 clocks, about 9600 baud at 50 MHz), so transmit and receive stay rate-matched. It synchronizes the raw `rx` pin, validates the start bit, and shifts in 8 data bits LSB first. For each frame it delivers one byte with a one-cycle strobe, or flags a framing error.

## Interface
- `CLKS_PER_BIT`, default 5201: clocks per serial bit. Legal range is ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer floor): clocks from start-bit detection to the start-bit mid-sample.

- `clk` input, 1 bit: system clock. The only clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `rx` input, 1 bit: asynchronous serial line. It idles high.
- `data` output, 8 bits: last correctly received byte. Held until the next good frame.
- `rx_done` output, 1 bit: one-cycle strobe. `data` is valid and new in the same cycle.
- `frame_err` output, 1 bit: one-cycle strobe. The stop bit was sampled low.

## Operation
- **Synchronizer:** `rx` passes through 2 flip-flops to produce `rx_s`. Both flops reset to 1.
- **IDLE:** `cnt`=0. On `rx_s`=0, go to START.
- **START:** count `HALF_BIT` clocks, then sample `rx_s`.
  - If 0, go to DATA with `cnt`=0 and `bit_idx`=0.
  - If 1, the event is a glitch: return to IDLE with no strobe.
- **DATA:** count `CLKS_PER_BIT` clocks, then sample `rx_s` into the shift register at position `bit_idx` (LSB first). After `bit_idx`=7 is sampled, go to STOP.
- **STOP:** count `CLKS_PER_BIT` clocks, then sample `rx_s`.
  - If 1: load `data` from the shift register, pulse `rx_done`, go to IDLE.
  - If 0: leave `data` unchanged, pulse `frame_err`, go to BREAK.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. A line held low never re-triggers a start.
- **Counter:** `cnt` is wide enough for `CLKS_PER_BIT`-1 and counts modulo the current limit. The sample is taken on the cycle where `cnt` = limit-1, and `cnt` returns to 0 on that cycle.
- **Reset:** reset at any point, including mid-frame, forces IDLE, `cnt`=0, `bit_idx`=0, and synchronizer = 1. A partial frame is discarded silently.
- **Concurrency:** `rx_done` and `frame_err` are never both high in the same cycle.

## Timing
- **Reset values:** `data`=8'h00, `rx_done`=0, `frame_err`=0.
- **Synchronizer latency:** 2 clocks from an `rx` edge to `rx_s`.
- **Strobe latency:** let T0 be the first clock edge at which IDLE sees `rx_s`=0. `rx_done` or `frame_err` is high during the cycle beginning at T0 + `HALF_BIT` + 9·`CLKS_PER_BIT`, for exactly one cycle.
- **Back-to-back frames:** the earliest next start is detected on the cycle after the strobe. Back-to-back frames with a single stop bit are therefore received without loss.
- **Glitch rejection:** a low pulse shorter than `HALF_BIT` clocks (after synchronization) is rejected.
- **Registered outputs:** all outputs are registered. There is no combinational path from `rx`.

## Structure
- **Shared package `uart_pkg`:**
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - Constant `UART_CLKS_PER_BIT` = 5201, shared with the divider and transmit stages.
  - Constant `UART_DATA_BITS` = 8.
- **Sub-module `sincronizador_2ff`:** parameterized reset value, 1-bit 2-flop synchronizer. It is reused by other pin inputs.
- **Top-level contents:** the FSM, counter and shift register live in the top level.

## Test plan
All scenarios run at `CLKS_PER_BIT`=16, `HALF_BIT`=8, with the bench driving `rx` on bit boundaries.
- **Single frame:** send 8'hA5 with stop=1 → one `rx_done` pulse at T0+152; `data`=8'hA5; `frame_err` never high.
- **Back-to-back:** send 8'h00 then 8'hFF with no idle gap → two `rx_done` pulses 160 clocks apart; `data`=8'h00, then 8'hFF.
- **Framing error:** send 8'h3C with stop=0, then hold `rx` low for 40 clocks, then release → one `frame_err` at T0+152; `data` keeps its prior value; no new start is accepted until `rx` has been high.
- **Glitch:**
  - Drive a 5-clock low pulse on idle `rx` → no strobe; FSM back in IDLE.
  - Then send 8'h81 → `data`=8'h81.
- **Reset mid-frame:** assert `reset` for 1 cycle during bit 4 of 8'h5A → outputs 0, no strobe for that frame; the next full frame 8'hC3 is received correctly.
- **Default parameter smoke test:** `CLKS_PER_BIT`=5201, send 8'h4B → `rx_done` at T0+2600+46809; `data`=8'h4B.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding used by the divider, transmit and receive stages.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 5201;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; reset value chosen per pin (idle level).
module sincronizador_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sincronizador_2ff

// File: rtl/receptor_uart.sv
// 8N1 serial receiver: synchronizes rx, validates the start bit at mid-bit, shifts in LSB first,
// and strobes either rx_done with a new byte or frame_err on a low stop bit.
module receptor_uart
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      rx_done,
    output logic                      frame_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      rx_done_q, rx_done_d;
    logic                      frame_err_q, frame_err_d;

    logic                      rx_s;
    logic [CNT_W-1:0]          limit_c;
    logic                      tick_c;

    sincronizador_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync_rx (
        .clk  (clk),
        .reset(reset),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // START waits half a bit to land mid-bit; every later phase waits a full bit.
    always_comb begin
        limit_c = (state_q == START) ? CNT_W'(HALF_BIT - 1) : CNT_W'(CLKS_PER_BIT - 1);
        tick_c  = (cnt_q == limit_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s) state_d = START;
            START: if (tick_c) state_d = rx_s ? IDLE : DATA;
            DATA:  if (tick_c && (bit_idx_q == IDX_W'(UART_DATA_BITS - 1))) state_d = STOP;
            STOP:  if (tick_c) state_d = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            START: begin
                cnt_d     = tick_c ? '0 : cnt_q + CNT_W'(1);
                bit_idx_d = '0;
            end
            DATA: begin
                if (tick_c) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (tick_c) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d    = shift_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule : receptor_uart

// File: tb/tb_receptor_uart.sv
// Randomized bench for receptor_uart: a frame-level model predicts strobe cycle and byte per frame.
module tb_receptor_uart;

    localparam int unsigned CPB      = 16;
    localparam int unsigned HALF     = 8;
    localparam int unsigned DEF_CPB  = 5201;
    localparam int unsigned DEF_HALF = 2600;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_def;
    logic [7:0] data, data_def;
    logic       rx_done, rx_done_def;
    logic       frame_err, frame_err_def;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned rst_cyc  = 32'hFFFF_FFFF;
    int unsigned def_exp  = 32'hFFFF_FFFF;
    bit          mon_en   = 1'b0;
    bit          def_seen = 1'b0;

    typedef struct {
        int unsigned cyc;
        bit          good;
        logic [7:0]  data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    logic [7:0] model_data = 8'h00;
    bit         exp_done, exp_err;

    receptor_uart #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );

    receptor_uart u_dut_def (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx_def),
        .data     (data_def),
        .rx_done  (rx_done_def),
        .frame_err(frame_err_def)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Holds rx at v for n clocks; returns #1 after a rising edge.
    task automatic hold(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit is driven at cycle c0; synchronizer + IDLE detection adds 3, then HALF + 9 bits.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int unsigned extra_low);
        ev_t e;
        e.cyc  = cyc + 3 + HALF + 9 * CPB;
        e.good = stop;
        e.data = b;
        exp_q.push_back(e);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
        if (!stop) hold(1'b0, extra_low);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (cyc == rst_cyc) begin
                exp_q.delete();
                model_data = 8'h00;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                if (ev.good) begin
                    exp_done   = 1'b1;
                    model_data = ev.data;
                end else begin
                    exp_err = 1'b1;
                end
            end
            check("rx_done", 32'(rx_done), 32'(exp_done));
            check("frame_err", 32'(frame_err), 32'(exp_err));
            check("data", 32'(data), 32'(model_data));
            if (rx_done_def || frame_err_def) begin
                check("def_done", 32'(rx_done_def), 32'd1);
                check("def_cyc", cyc, def_exp);
                check("def_data", 32'(data_def), 32'h4B);
                def_seen = 1'b1;
            end
        end
    end

    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        rx_def = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_data", 32'(data), 32'h00);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        mon_en = 1'b1;

        hold(1'b1, 20);
        send_frame(8'hA5, 1'b1, 0);
        hold(1'b1, 10);

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        hold(1'b1, 10);

        send_frame(8'h3C, 1'b0, 40);
        hold(1'b1, 30);

        hold(1'b0, 5);
        hold(1'b1, 30);
        send_frame(8'h81, 1'b1, 0);
        hold(1'b1, 10);

        // 8'h5A interrupted by reset during bit 4 (a '1'), line then left idle.
        hold(1'b0, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b1, 8);
        reset   = 1'b1;
        rst_cyc = cyc + 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold(1'b1, 40);
        send_frame(8'hC3, 1'b1, 0);
        hold(1'b1, 10);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            bit         stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                hold(1'b0, $urandom_range(1, HALF - 1));
                hold(1'b1, 20);
            end
            send_frame(b, stop, stop ? 0 : $urandom_range(0, 30));
            if (!stop) hold(1'b1, $urandom_range(3, 20));
            else if ($urandom_range(0, 2) != 0) hold(1'b1, $urandom_range(1, 20));
        end

        hold(1'b1, 200);
        check("pending_frames", exp_q.size(), 0);

        def_exp = cyc + 3 + DEF_HALF + 9 * DEF_CPB;
        rx_def  = 1'b0;
        repeat (DEF_CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] db;
            db = 8'h4B;
            #1 rx_def = db[i];
            repeat (DEF_CPB) @(posedge clk);
        end
        #1 rx_def = 1'b1;
        repeat (DEF_CPB) @(posedge clk);
        while (!def_seen && cyc < def_exp + 20) @(posedge clk);
        #1;
        check("def_seen", 32'(def_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_receptor_uart
